// File: rtl/pond_output_fifo.sv
// pond_output_fifo: first-word-fall-through staging FIFO between the pond read port
// and the interconnect, with occupancy reporting and a sticky dropped-read flag.
module pond_output_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  pop;
    logic                  push_ok;
    logic                  step;

    assign empty     = count == '0;
    assign full      = count == CNT_WIDTH'(DEPTH);
    assign valid_out = ~empty;
    assign data_out  = storage[rd_ptr];
    assign pop       = valid_out & ready_in;
    // A pop on a full FIFO frees the slot being written on the same edge.
    assign push_ok   = valid_in & (~full | pop);
    assign step      = clk_en & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                rd_ptr   <= rd_ptr + PW'(pop);
                wr_ptr   <= wr_ptr + PW'(push_ok);
                count    <= count + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop);
                overflow <= overflow | (valid_in & ~push_ok);
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (step && push_ok) storage[wr_ptr] <= data_in;
    end
endmodule

// File: tb/tb_pond_output_fifo.sv
// tb_pond_output_fifo: table-driven vectors plus a data scoreboard for pond_output_fifo.
module tb_pond_output_fifo;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    int            n_checks = 0;
    int            n_fail = 0;
    int            popped = 0;
    logic [DW-1:0] q[$];

    typedef struct {
        logic          ce;
        logic          fl;
        logic          vi;
        logic          rdy;
        logic [DW-1:0] d;
        logic          acc;
        int            cnt;
        logic          ovf;
    } vec_t;
    vec_t vecs[$];

    pond_output_fifo #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
        .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .count(count),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic ovf);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " full"}, 32'(full), 32'(cnt == D));
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, " valid_out"}, 32'(valid_out), 32'(cnt != 0));
        chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
    endtask

    // One clock: drive at negedge, check head against the scoreboard, update it at the edge.
    task automatic cyc(input logic ce, input logic fl, input logic vi, input logic rdy,
                       input logic [DW-1:0] d, input logic acc);
        logic pv;
        @(negedge clk);
        clk_en = ce; flush = fl; valid_in = vi; ready_in = rdy; data_in = d;
        #1;
        pv = valid_out;
        chk("head valid", 32'(valid_out), 32'(q.size() != 0));
        if (q.size() != 0) chk("head data", 32'(data_out), 32'(q[0]));
        @(posedge clk);
        if (ce && fl) q.delete();
        else if (ce) begin
            if (pv && rdy) begin
                void'(q.pop_front());
                popped++;
            end
            if (acc) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        #12;
        chk_state("reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // fill, drop on full, drain, then flush a non-empty FIFO
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0033, 1'b1, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0044, 1'b1, 4, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0055, 1'b0, 4, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0077, 1'b1, 1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'h00EE, 1'b0, 0, 1'b0});
        // full with simultaneous push and pop
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 4, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b1, 4, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 3, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b0});
        // clock-enable gating, including a flush while gated
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h00B1, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h00B2, 1'b1, 2, 1'b0});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h00C0, 1'b0, 2, 1'b0});
        for (int i = 0; i < 2; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'h00C1, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b0});

        foreach (vecs[i]) begin
            cyc(vecs[i].ce, vecs[i].fl, vecs[i].vi, vecs[i].rdy, vecs[i].d, vecs[i].acc);
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf);
        end

        // wrap-around under alternating backpressure, including push into empty with ready high
        popped = 0;
        for (int i = 0; i < 22; i++)
            cyc(1'b1, 1'b0, (i < 20) && (i % 2 == 0), i % 2 == 0, DW'(16'h0100 + i / 2),
                (i < 20) && (i % 2 == 0));
        chk("wrap popped", 32'(popped), 32'd10);
        chk_state("wrap end", 0, 1'b0);

        // asynchronous reset mid-run with three words held
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(16'h0200 + i), 1'b1);
        chk_state("pre-reset", 3, 1'b0);
        valid_in = 1'b0;
        #3 rst = 1'b1;
        #1;
        q.delete();
        chk_state("mid reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
            chk_state("idle", 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pond_output_fifo.md
Name: pond_output_fifo

Overview:
- Output staging buffer directly downstream of the pond memory tile.
- Captures the pond read word on every cycle its read schedule asserts the accessor-valid strobe, holds it in a small FIFO, and presents it to the interconnect with a valid/ready handshake.
- Decouples the pond's fixed-schedule reads from downstream backpressure.
- Reports occupancy, and sets a sticky flag when a scheduled read is lost.

Parameters:
- DATA_WIDTH, 16, width of one data word; matches the pond word width.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  tile clock (gated tile clock)
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  global clock enable; when low, all state holds
- flush  in  1  synchronous clear, qualified by clk_en
- data_in  in  DATA_WIDTH  pond read data (combinational from pond)
- valid_in  in  1  pond read accessor-valid strobe; push request
- ready_in  in  1  downstream ready
- data_out  out  DATA_WIDTH  head-of-FIFO word
- valid_out  out  1  head word valid
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (rst high, asynchronous):
  - rd_ptr, wr_ptr, count and overflow go to 0.
  - Outputs after reset: valid_out=0, empty=1, full=0, count=0, overflow=0.
  - data_out is don't-care; storage is not reset.
- clk_en=0: pointers, count, storage and overflow all hold. Outputs remain combinational from held state.
- flush=1 with clk_en=1: same clear as reset on that edge; push and pop in the same cycle are ignored.
- Handshake definitions:
  - pop = valid_out & ready_in.
  - push_ok = valid_in & (~full | pop).
- Push: on the clock edge with push_ok, storage[wr_ptr] <= data_in and wr_ptr increments.
- Pop: on the clock edge with pop, rd_ptr increments.
- count update: count <= count + push_ok - pop.
- Pointer width: log2(DEPTH) bits, wrapping modulo DEPTH naturally. count is separate and unambiguously distinguishes full from empty.
- Output path: first-word-fall-through.
  - valid_out = ~empty.
  - data_out = storage[rd_ptr], combinational from storage.
  - Latency from push to valid_out is 1 cycle. There is no same-cycle bypass when empty.
- Full with push and pop in the same cycle: both occur and count stays at DEPTH. No overflow.
- Full with push and no pop: the word is dropped, storage and pointers are unchanged, and overflow <= 1.
  - overflow stays set until rst or flush.
  - It is not cleared by draining the FIFO.
- Empty with pop: impossible, since valid_out=0.
- Empty with push and ready_in=1: the word is written. It is not popped this cycle; it appears next cycle.
- ready_in is ignored while valid_out=0.
- data_out and valid_out must remain stable while valid_out=1 and ready_in=0.
- No combinational path from ready_in to any output other than through state. full, empty and count are registered-derived.

Test Plan:
- Reset and idle: assert rst mid-run with count=3 -> next sample valid_out=0, count=0, empty=1, overflow=0. Release rst and hold valid_in=0 for 10 cycles -> outputs unchanged.
- Fill and drain in order: ready_in=0, push 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles -> count=4, full=1, data_out=0x0011. Then ready_in=1 for 4 cycles -> data_out sequence 0x0011, 0x0022, 0x0033, 0x0044, then empty=1.
- Overflow: with full=1 and ready_in=0, push 0x0055 -> count stays 4 and overflow=1. Drain all -> 0x0055 never appears and overflow stays 1. Then flush=1 for one cycle -> overflow=0, count=0.
- Simultaneous push and pop when full: full=1, ready_in=1, push 0x00AA -> count stays 4 and overflow=0. 0x00AA emerges after the three older words.
- Wrap-around and backpressure: push 10 words (0x0100..0x0109) while ready_in toggles 1,0,1,0,... -> output order 0x0100..0x0109 with no loss. data_out is stable during every ready_in=0 cycle with valid_out=1.
- clk_en gating: clk_en=0 for 5 cycles while valid_in=1 and ready_in=1 -> count, data_out and pointers unchanged. flush asserted during clk_en=0 has no effect.
